// File: rtl/ofd4_sched_pkg.sv
// Shared definitions for the nibble-serial word scheduler.
// State codes, nibble geometry and the round-robin pick function.
package ofd4_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int NIB_W  = 4;
  localparam int NNIB   = 16 / NIB_W;
  localparam int MAXREQ = 4;

  // First asserted request after ptr, wrapping modulo n.
  function automatic logic [1:0] rr_pick(
    input logic [MAXREQ-1:0] req,
    input logic [1:0]        ptr,
    input int                n
  );
    logic [1:0] pick;
    logic [1:0] idx;
    logic       hit;
    pick = '0;
    hit  = 1'b0;
    for (int s = 1; s <= MAXREQ; s++) begin
      idx = 2'((int'(ptr) + s) % n);
      if (s <= n && !hit && req[idx]) begin
        pick = idx;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ofd4_word_sched_arb.sv
// Round-robin arbiter: combinational pick plus last-grant pointer.
// Pointer resets to NREQ-1 so requester 0 wins the first slot.
module ofd4_rr_arb
  import ofd4_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            i_ck,
  input  logic            i_clr,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_take,
  output logic [1:0]      o_pick,
  output logic            o_any
);

  logic [1:0]        r_ptr;
  logic [MAXREQ-1:0] w_req;

  always_comb begin
    w_req = '0;
    w_req[NREQ-1:0] = i_req;
  end

  assign o_pick = rr_pick(w_req, r_ptr, NREQ);
  assign o_any  = |i_req;

  always_ff @(posedge i_ck or posedge i_clr) begin
    if (i_clr) begin
      r_ptr <= 2'(NREQ - 1);
    end else if (i_take) begin
      r_ptr <= o_pick;
    end
  end

endmodule

// File: rtl/ofd4_word_sched.sv
// Serialises granted requester words MSB-nibble-first onto D3..D0,
// with FRM on the first nibble and a programmable idle gap per word.
module ofd4_word_sched
  import ofd4_sched_pkg::*;
#(
  parameter int          NREQ     = 2,
  parameter int          WORD_W   = 16,
  parameter int          GAP      = 1,
  parameter logic [3:0]  IDLE_NIB = 4'h0
) (
  input  logic                   CK,
  input  logic                   CLR,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ*WORD_W-1:0] WDATA,
  output logic [NREQ-1:0]        ACK,
  output logic                   D0,
  output logic                   D1,
  output logic                   D2,
  output logic                   D3,
  output logic                   FRM,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int LN = WORD_W / NIB_W;
  localparam int CW = (LN > 1) ? $clog2(LN) : 1;
  localparam logic [CW-1:0] CLAST = CW'(LN - 1);
  localparam logic [3:0]    GLAST = 4'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]        r_st;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_g;
  logic [WORD_W-1:0] r_sh;
  logic [3:0]        r_d;
  logic              r_frm;
  logic              r_busy;
  logic              r_done;
  logic [NREQ-1:0]   r_ack;

  logic [1:0]        w_st_n;
  logic [CW-1:0]     w_cnt_n;
  logic [3:0]        w_g_n;
  logic [WORD_W-1:0] w_sh_n;
  logic [3:0]        w_d_n;
  logic              w_frm_n;
  logic [NREQ-1:0]   w_ack_n;

  logic [1:0]        w_pick;
  logic              w_any;
  logic              w_last_nib;
  logic              w_last_gap;
  logic              w_arb;
  logic              w_take;
  logic [WORD_W-1:0] w_word;

  ofd4_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_ck   (CK),
    .i_clr  (CLR),
    .i_req  (REQ),
    .i_take (w_take),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  assign w_last_nib = (r_st == ST_SEND) && (r_cnt == CLAST);
  assign w_last_gap = (r_st == ST_GAP) && (r_g == GLAST);
  assign w_arb  = (r_st == ST_IDLE)
                | (w_last_nib && (GAP == 0))
                | w_last_gap;
  assign w_take = w_arb & w_any;
  assign w_word = WDATA[int'(w_pick)*WORD_W +: WORD_W];

  always_comb begin
    w_st_n  = r_st;
    w_cnt_n = r_cnt;
    w_g_n   = r_g;
    w_sh_n  = r_sh;
    w_d_n   = IDLE_NIB;
    w_frm_n = 1'b0;
    w_ack_n = '0;
    unique case (1'b1)
      w_take: begin
        w_st_n  = ST_SEND;
        w_cnt_n = '0;
        w_sh_n  = w_word << NIB_W;
        w_d_n   = w_word[WORD_W-1 -: 4];
        w_frm_n = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
          w_ack_n[k] = (w_pick == 2'(k));
        end
      end
      (!w_take && r_st == ST_SEND && !w_last_nib): begin
        w_cnt_n = r_cnt + 1'b1;
        w_d_n   = r_sh[WORD_W-1 -: 4];
        w_sh_n  = r_sh << NIB_W;
      end
      (!w_take && w_last_nib): begin
        w_st_n = (GAP > 0) ? ST_GAP : ST_IDLE;
        w_g_n  = '0;
      end
      (!w_take && r_st == ST_GAP && !w_last_gap): begin
        w_g_n = r_g + 4'd1;
      end
      default: begin
        w_st_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_g    <= '0;
      r_sh   <= '0;
      r_d    <= IDLE_NIB;
      r_frm  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ack  <= '0;
    end else begin
      r_st   <= w_st_n;
      r_cnt  <= w_cnt_n;
      r_g    <= w_g_n;
      r_sh   <= w_sh_n;
      r_d    <= w_d_n;
      r_frm  <= w_frm_n;
      r_busy <= (w_st_n != ST_IDLE);
      r_done <= w_last_nib;
      r_ack  <= w_ack_n;
    end
  end

  assign {D3, D2, D1, D0} = r_d;
  assign FRM  = r_frm;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ACK  = r_ack;

endmodule

// File: doc/ofd4_word_sched.md
Name: ofd4_word_sched

Overview:
Round-robin scheduler that shares one 4-bit output flip-flop bank (D0..D3 inputs of the IOB output register group) between NREQ requesters.
- Each granted requester's word is serialized MSB-nibble-first onto D0..D3, one nibble per CK.
- FRM marks the first nibble of each word.
- A programmable idle gap separates consecutive words.
- The block sits directly upstream of the 4-wide output register and is the only driver of its D inputs.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- WORD_W, 16, word width in bits; must be a multiple of 4; NNIB = WORD_W/4.
- GAP, 1, idle cycles inserted after each word (legal 0..15).
- IDLE_NIB, 4'h0, value driven on D0..D3 when no nibble is being sent.

Ports:
- CK  input  1  clock, rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- REQ  input  NREQ  per-requester request level; held until matching ACK.
- WDATA  input  NREQ*WORD_W  requester words; requester k occupies bits [k*WORD_W +: WORD_W].
- ACK  output  NREQ  one-cycle pulse; word of requester k accepted.
- D0  output  1  nibble bit 0 to output register.
- D1  output  1  nibble bit 1.
- D2  output  1  nibble bit 2.
- D3  output  1  nibble bit 3.
- FRM  output  1  high with the first nibble of each word.
- BUSY  output  1  high while state is not IDLE.
- DONE  output  1  one-cycle pulse after the last nibble of a word.

Behaviour:
- Interface: one clock, CK. Reset is asynchronous and active-high on CLR.
- Reset (CLR=1, asynchronous): state=IDLE; {D3..D0}=IDLE_NIB; FRM=0; ACK=0; DONE=0; BUSY=0; nibble and gap counters=0; RR pointer=NREQ-1, so requester 0 has first priority.
- CLR mid-word aborts the word: no DONE, remaining nibbles discarded, no ACK replay.
- All outputs are registered.
- States:
  - IDLE: no word in flight.
  - SEND: nibble counter cnt = 0..NNIB-1.
  - GAP: gap counter g = 0..GAP-1.
- Arbitration slot (ARB) exists in any of these cycles:
  - state IDLE;
  - last SEND cycle (cnt=NNIB-1) when GAP=0;
  - last GAP cycle (g=GAP-1).
- Grant rule in an ARB cycle with REQ!=0:
  - Grant k = first asserted REQ searching from pointer+1, modulo NREQ.
  - At the next edge: load shift reg with WDATA[k]; {D3..D0}=WDATA[k][WORD_W-1 -: 4]; FRM=1; ACK[k]=1 for exactly one cycle; pointer=k; state=SEND, cnt=0.
- SEND, cnt<NNIB-1: next edge drives the next lower nibble; FRM=0; cnt++.
- SEND, cnt=NNIB-1:
  - Next edge: DONE=1 for one cycle.
  - If GAP>0: state=GAP, g=0, D=IDLE_NIB.
  - If GAP=0 with a grant: the next word's first nibble follows back-to-back, with FRM=1.
  - If GAP=0 with no grant: state=IDLE, D=IDLE_NIB.
- GAP: D=IDLE_NIB, g++. At g=GAP-1: if a grant occurs, go to SEND; otherwise go to IDLE.
- WDATA is sampled only in the ARB cycle. Later changes do not affect the word in flight.
- If REQ drops before ACK, the request is withdrawn; there is no error.
- ACK and the first nibble appear in the same cycle.
- Latency: REQ rise in an IDLE cycle -> first nibble and ACK 1 cycle later.
- Word period is NNIB+GAP cycles.
- BUSY is 1 in SEND and GAP, including the gap cycles.
- Simultaneous requests: exactly one ACK bit may be high in any cycle.
- Fairness: with all REQ held high, grants rotate 0,1,..,NREQ-1,0,...

Decomposition:
- Shared package ofd4_sched_pkg:
  - state encoding IDLE/SEND/GAP;
  - function rr_pick(req, ptr) returning the grant index;
  - localparam NNIB.
- One natural sub-module: ofd4_rr_arb (combinational rr_pick plus pointer register). The shift/sequencing FSM stays in the top module.

Test Plan:
- Reset/idle: CLR pulse, REQ=0 for 10 cycles -> D=4'h0, FRM=BUSY=DONE=ACK=0 throughout.
- Single word: GAP=1, REQ[0]=1 with WDATA0=16'hA5C3 -> ACK[0] pulse; D sequence A,5,C,3 on four consecutive cycles; FRM only on A; DONE pulse in the following cycle; then D=0 for 1 gap cycle; BUSY high for 5 cycles.
- Round-robin: NREQ=2, both REQ held, WDATA0=16'h1111, WDATA1=16'h2222 -> words alternate 1111, 2222, 1111; each ACK is a single pulse at its word's first nibble.
- Back-to-back: GAP=0, REQ[1] held, WDATA1=16'h0F0F -> FRM every 4th cycle; D=0,F,0,F repeating with no IDLE cycle; DONE coincides with each FRM after the first.
- Reset mid-word: assert CLR after second nibble of 16'h1234 -> D=0, FRM=0, BUSY=0 immediately (asynchronous); no DONE; next grant goes to requester 0.
- Withdraw/sampling: REQ[1] deasserted during another word's SEND -> no ACK[1]. WDATA0 changed after ACK[0] -> serialized nibbles match the value captured at ACK.
